// File: rtl/bt_frame_decoder_pkg.sv
// Shared types and constants for the Bluetooth command-frame decoder and the
// game logic that consumes its commands.
package bt_frame_decoder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_ARG  = 2'd2,
        S_CHK  = 2'd3
    } bt_state_e;

    localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;

    localparam logic [7:0] CMD_MOVE  = 8'h01;
    localparam logic [7:0] CMD_FIRE  = 8'h02;
    localparam logic [7:0] CMD_PAUSE = 8'h03;

    function automatic logic [7:0] frame_checksum(input logic [7:0] cmd, input logic [7:0] arg);
        return cmd ^ arg;
    endfunction

endpackage

// File: rtl/bt_frame_decoder_if.sv
// Byte input from the UART receiver plus the decoded-command outputs.
// Handshake: rx_done is a one-cycle strobe qualifying rx_data; there is no
// backpressure, so every strobed byte must be taken in the cycle it appears.
interface bt_frame_decoder_if #(
    parameter int ERR_W = 8
);
    logic [7:0]       rx_data;
    logic             rx_done;
    logic [7:0]       cmd_out;
    logic [7:0]       arg_out;
    logic             cmd_valid;
    logic             err_chk;
    logic             err_timeout;
    logic [ERR_W-1:0] err_count;
    logic             busy;

    modport master (
        output rx_data, rx_done,
        input  cmd_out, arg_out, cmd_valid, err_chk, err_timeout, err_count, busy
    );

    modport slave (
        input  rx_data, rx_done,
        output cmd_out, arg_out, cmd_valid, err_chk, err_timeout, err_count, busy
    );
endinterface

// File: rtl/bt_timeout_timer.sv
// Inter-byte stall timer: counts while run is high, clears on clear, and
// pulses tc on the cycle whose edge would bring the count to TIMEOUT_CYCLES-1.
module bt_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clkcapture,
    input  logic enable,
    input  logic clear_i,
    input  logic run_i,
    output logic tc_o
);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TC_VAL = TW'(TIMEOUT_CYCLES - 2);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    // A byte arriving on the terminal cycle suppresses the timeout.
    assign tc_o = run_i && !clear_i && (timer_q == TC_VAL);

    always_comb begin
        timer_d = timer_q;
        if (clear_i || tc_o) begin
            timer_d = '0;
        end else if (run_i) begin
            timer_d = timer_q + TW'(1);
        end
    end

    always_ff @(posedge clkcapture or posedge enable) begin
        if (enable) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
endmodule

// File: rtl/bt_frame_decoder.sv
// Assembles SOF/CMD/ARG/CHK frames from received bytes, verifies the XOR
// checksum, strobes good commands and counts checksum/timeout errors.
module bt_frame_decoder
    import bt_frame_decoder_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE       = SOF_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter int         ERR_W          = 8
) (
    input  logic                     clkcapture,
    input  logic                     enable,
    bt_frame_decoder_if.slave        bus,
    output bt_state_e                state_o
);
    bt_state_e        state_q;
    logic [7:0]       cmd_reg_q;
    logic [7:0]       arg_reg_q;
    logic [7:0]       cmd_out_q;
    logic [7:0]       arg_out_q;
    logic             cmd_valid_q;
    logic             err_chk_q;
    logic             err_timeout_q;
    logic [ERR_W-1:0] err_count_q;
    logic             tmo_tc;
    logic             busy;

    assign busy = (state_q != S_IDLE);

    bt_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clkcapture (clkcapture),
        .enable     (enable),
        .clear_i    (bus.rx_done || !busy),
        .run_i      (busy),
        .tc_o       (tmo_tc)
    );

    always_ff @(posedge clkcapture or posedge enable) begin
        if (enable) begin
            state_q       <= S_IDLE;
            cmd_reg_q     <= '0;
            arg_reg_q     <= '0;
            cmd_out_q     <= '0;
            arg_out_q     <= '0;
            cmd_valid_q   <= 1'b0;
            err_chk_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_count_q   <= '0;
        end else begin
            cmd_valid_q   <= 1'b0;
            err_chk_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            if (bus.rx_done) begin
                case (state_q)
                    S_IDLE: begin
                        if (bus.rx_data == SOF_BYTE) state_q <= S_CMD;
                    end
                    S_CMD: begin
                        cmd_reg_q <= bus.rx_data;
                        state_q   <= S_ARG;
                    end
                    S_ARG: begin
                        arg_reg_q <= bus.rx_data;
                        state_q   <= S_CHK;
                    end
                    S_CHK: begin
                        if (bus.rx_data == frame_checksum(cmd_reg_q, arg_reg_q)) begin
                            cmd_out_q   <= cmd_reg_q;
                            arg_out_q   <= arg_reg_q;
                            cmd_valid_q <= 1'b1;
                        end else begin
                            err_chk_q <= 1'b1;
                            if (err_count_q != {ERR_W{1'b1}}) err_count_q <= err_count_q + ERR_W'(1);
                        end
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end else if (tmo_tc) begin
                // Stalled mid-frame: drop the partial frame.
                err_timeout_q <= 1'b1;
                if (err_count_q != {ERR_W{1'b1}}) err_count_q <= err_count_q + ERR_W'(1);
                state_q <= S_IDLE;
            end
        end
    end

    assign bus.cmd_out     = cmd_out_q;
    assign bus.arg_out     = arg_out_q;
    assign bus.cmd_valid   = cmd_valid_q;
    assign bus.err_chk     = err_chk_q;
    assign bus.err_timeout = err_timeout_q;
    assign bus.err_count   = err_count_q;
    assign bus.busy        = busy;
    assign state_o         = state_q;
endmodule

// File: tb/tb_bt_frame_decoder.sv
// Directed bench for bt_frame_decoder: a frame-level reference model checked
// against the DUT every cycle, plus hand-computed literal checks.
module tb_bt_frame_decoder;
    import bt_frame_decoder_pkg::*;

    localparam int         TMO   = 100;
    localparam int         ERR_W = 8;
    localparam logic [7:0] SOF   = 8'hA5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic enable = 1'b1;
    always #5 clk = ~clk;

    bt_frame_decoder_if #(.ERR_W(ERR_W)) bus ();
    bt_state_e state_dbg;

    bt_frame_decoder #(
        .SOF_BYTE       (SOF),
        .TIMEOUT_CYCLES (TMO),
        .ERR_W          (ERR_W)
    ) dut (
        .clkcapture (clk),
        .enable     (enable),
        .bus        (bus),
        .state_o    (state_dbg)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit running  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Bytes of the frame in progress; empty means hunting for SOF.
    logic [7:0]       frame_q[$];
    int               gap = 0;
    logic [7:0]       m_cmd = 8'h00;
    logic [7:0]       m_arg = 8'h00;
    logic             m_valid = 1'b0;
    logic             m_chk = 1'b0;
    logic             m_tmo = 1'b0;
    logic [ERR_W-1:0] m_errs = '0;
    int               exp_errs_int;

    always @(posedge clk or posedge enable) begin
        if (enable) begin
            frame_q.delete();
            gap = 0;
            m_cmd = 8'h00; m_arg = 8'h00;
            m_valid = 1'b0; m_chk = 1'b0; m_tmo = 1'b0;
            m_errs = '0;
        end else begin
            m_valid = 1'b0; m_chk = 1'b0; m_tmo = 1'b0;
            if (bus.rx_done) begin
                gap = 0;
                if (frame_q.size() != 0 || bus.rx_data == SOF) frame_q.push_back(bus.rx_data);
                if (frame_q.size() == 4) begin
                    if ((frame_q[1] ^ frame_q[2]) == frame_q[3]) begin
                        m_valid = 1'b1;
                        m_cmd = frame_q[1];
                        m_arg = frame_q[2];
                    end else begin
                        m_chk = 1'b1;
                        exp_errs_int = int'(m_errs) + 1;
                        if (exp_errs_int < (1 << ERR_W)) m_errs = ERR_W'(exp_errs_int);
                    end
                    frame_q.delete();
                end
            end else if (frame_q.size() != 0) begin
                gap++;
                if (gap == TMO - 1) begin
                    m_tmo = 1'b1;
                    exp_errs_int = int'(m_errs) + 1;
                    if (exp_errs_int < (1 << ERR_W)) m_errs = ERR_W'(exp_errs_int);
                    frame_q.delete();
                end
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (running) begin
            check("cmd_out",     32'(bus.cmd_out),     32'(m_cmd));
            check("arg_out",     32'(bus.arg_out),     32'(m_arg));
            check("cmd_valid",   32'(bus.cmd_valid),   32'(m_valid));
            check("err_chk",     32'(bus.err_chk),     32'(m_chk));
            check("err_timeout", 32'(bus.err_timeout), 32'(m_tmo));
            check("err_count",   32'(bus.err_count),   32'(m_errs));
            check("busy",        32'(bus.busy),        32'(frame_q.size() != 0));
        end
    end

    // ---------------- drivers ----------------
    // Both tasks are entered and left 1 time unit after a rising edge.
    task automatic strobe(input logic [7:0] b);
        bus.rx_done = 1'b1;
        bus.rx_data = b;
        @(posedge clk); #1;
        bus.rx_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k);
        strobe(SOF); strobe(c); strobe(a); strobe(k);
    endtask

    int tmo_at;

    initial begin
        bus.rx_done = 1'b0;
        bus.rx_data = 8'h00;
        running = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_out",   32'(bus.cmd_out), 32'h00);
        check("rst_busy",      32'(bus.busy), 32'h0);
        check("rst_err_count", 32'(bus.err_count), 32'h0);
        check("rst_state",     32'(state_dbg), 32'(S_IDLE));
        enable = 1'b0;
        idle(2);

        // Good frame, bytes five cycles apart.
        strobe(SOF); idle(4); strobe(CMD_MOVE); idle(4); strobe(CMD_FIRE); idle(4); strobe(8'h03);
        check("good_valid_pulse", 32'(bus.cmd_valid), 32'h1);
        idle(1);
        check("good_valid_drop", 32'(bus.cmd_valid), 32'h0);
        check("good_cmd", 32'(bus.cmd_out), 32'h01);
        check("good_arg", 32'(bus.arg_out), 32'h02);
        check("good_errs", 32'(bus.err_count), 32'h0);

        // Bad checksum, then a good frame.
        frame(8'h01, 8'h02, 8'h07);
        check("badchk_pulse", 32'(bus.err_chk), 32'h1);
        idle(1);
        check("badchk_errs", 32'(bus.err_count), 32'h1);
        check("badchk_cmd_held", 32'(bus.cmd_out), 32'h01);
        frame(8'h02, 8'h05, 8'h07);
        check("after_bad_valid", 32'(bus.cmd_valid), 32'h1);
        check("after_bad_cmd", 32'(bus.cmd_out), 32'h02);
        check("after_bad_arg", 32'(bus.arg_out), 32'h05);
        idle(2);

        // Idle garbage followed by a back-to-back frame.
        strobe(8'h55); strobe(8'h12);
        frame(8'h03, 8'h00, 8'h03);
        check("garbage_valid", 32'(bus.cmd_valid), 32'h1);
        check("garbage_cmd", 32'(bus.cmd_out), 32'h03);
        check("garbage_arg", 32'(bus.arg_out), 32'h00);
        check("garbage_errs", 32'(bus.err_count), 32'h1);
        idle(2);

        // Timeout: pulse must land 99 cycles after the last strobe.
        strobe(SOF); strobe(8'h01);
        tmo_at = 0;
        for (int k = 1; k <= 150; k++) begin
            @(posedge clk); #1;
            if (bus.err_timeout && tmo_at == 0) begin
                tmo_at = k;
                break;
            end
        end
        check("tmo_latency", 32'(tmo_at), 32'd99);
        check("tmo_busy", 32'(bus.busy), 32'h0);
        check("tmo_errs", 32'(bus.err_count), 32'h2);
        idle(3);

        // Byte on the terminal cycle wins over the timeout.
        strobe(SOF); strobe(8'h01); idle(98); strobe(8'h02);
        check("tc_byte_no_tmo", 32'(bus.err_timeout), 32'h0);
        check("tc_byte_busy", 32'(bus.busy), 32'h1);
        strobe(8'h03);
        check("tc_byte_valid", 32'(bus.cmd_valid), 32'h1);
        idle(2);

        // Saturation of the error counter.
        for (int i = 0; i < 260; i++) frame(8'h01, 8'h02, 8'h00);
        idle(1);
        check("sat_errs", 32'(bus.err_count), 32'hFF);

        // Asynchronous reset mid-frame.
        strobe(SOF); strobe(8'h01);
        #3 enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_state", 32'(state_dbg), 32'(S_IDLE));
        check("midrst_cmd", 32'(bus.cmd_out), 32'h00);
        check("midrst_errs", 32'(bus.err_count), 32'h0);
        check("midrst_busy", 32'(bus.busy), 32'h0);
        enable = 1'b0;
        idle(1);
        check("midrst_release_quiet", 32'(bus.cmd_valid | bus.err_chk | bus.err_timeout), 32'h0);
        frame(8'h04, 8'h04, 8'h00);
        check("postrst_valid", 32'(bus.cmd_valid), 32'h1);
        check("postrst_cmd", 32'(bus.cmd_out), 32'h04);
        check("postrst_arg", 32'(bus.arg_out), 32'h04);
        idle(3);

        running = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
